pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready flow control, an optional two-entry skid buffer, and synchronous flush. It replaces the fixed-field, always-loading inter-stage registers between fetch, decode, execute, memory and writeback. Each boundary instantiates one copy with the concatenated stage payload as `in_data`, so the upstream stage sees back-pressure and the hazard unit gets a single flush input per stage.

## Interface
- `WIDTH`, default 16: payload width in bits; legal range 1..256.
- `NOP`, default `{WIDTH{1'b0}}`: payload value held in any empty entry and driven on `out_data` while `out_valid`=0.
- `SKID`, default 1: 1 gives a two-entry skid buffer with registered `in_ready`; 0 gives a single entry with combinational `in_ready`.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: upstream beat present.
- `in_ready`  out  1: stage can accept a beat this cycle.
- `in_data`  in  WIDTH: upstream payload.
- `out_valid`  out  1: head entry valid.
- `out_ready`  in  1: downstream accepts the head this cycle.
- `out_data`  out  WIDTH: head payload.
- `flush`  in  1: synchronous kill of all held entries and of the incoming beat.
- `occupancy`  out  2: number of valid entries, 0..2 (0..1 when `SKID`=0).

## Operation
- Entries: main M, which drives `out_*`, and skid S, present only when `SKID`=1. Each entry is a valid bit plus a WIDTH data field.
- Handshake terms:
  - Accept = `in_valid` & `in_ready`.
  - Fire = `out_valid` & `out_ready`.
  - `out_valid` = M.valid.
- `SKID`=1:
  - `in_ready` = !S.valid. This is a pure register output with no path from `out_ready`.
  - M empty: an accepted beat loads M.
  - M full and Fire:
    - If S.valid, M<=S and S empties.
    - Else, M<=in on Accept, otherwise M empties.
  - M full and no Fire: an accepted beat loads S. Accept with S full cannot occur.
- `SKID`=0:
  - `in_ready` = !M.valid | `out_ready`.
  - Accept loads M.
  - Fire without Accept empties M.
- Emptying an entry also writes `NOP` into its data field.
- Order is strictly FIFO. Beats are never duplicated, reordered or dropped except by `flush`.
- `flush` (priority over all other updates):
  - Next cycle M and S are empty, both data fields are `NOP`, and `occupancy`=0.
  - A Fire in the flush cycle counts as completed downstream.
  - An Accept in the flush cycle is discarded.
- Data bits of `in_data` are captured unmodified. X on `in_data` is permitted when `in_valid`=0 and never propagates to `out_data`.

## Timing
- Reset values: `out_valid`=0, `out_data`=`NOP`, `occupancy`=0, `in_ready`=1.
  - Outputs take these values asynchronously on `reset` assertion.
  - They hold them until the first rising edge after deassertion.
- Latency: 1 cycle from Accept to `out_valid` of that beat.
- Throughput: one beat per cycle with `out_ready` held at 1, for both `SKID` values.
- With `SKID`=1, `in_ready` falls one cycle after the first stalled Accept into a full M. Exactly one extra beat is absorbed.
- Simultaneous Accept and Fire with S empty: occupancy is unchanged and M takes the new beat.
- Reset mid-operation: all entries are lost immediately. There is no recovery of in-flight beats.
- `flush` and `reset` both asserted: `reset` dominates. The result is identical.

## Structure
- Shared package `pipe_pkg`:
  - `PIPE_OCC_W`=2.
  - Default NOP encoding `PIPE_NOP16`.
  - Per-stage payload width constants (`IF_ID_W`, `ID_EX_W`, `EX_MEM_W`, `MEM_WB_W`), used by the top-level instantiations.
- Sub-module `pipe_slot`: one entry (valid bit plus WIDTH data) with `load`, `clear` and `reset` inputs.
  - `clear` writes `NOP`.
  - `pipe_stage_reg` instantiates two slots under `SKID`=1 and one slot under `SKID`=0, selected by a generate block.

## Test plan
- Reset, then idle:
  - During `reset`: `out_valid`=0, `out_data`=0x0000, `in_ready`=1, `occupancy`=0.
  - Same values after release with `in_valid`=0.
- Streaming, `SKID`=1, `out_ready`=1: inject 0x0001..0x0010 back-to-back.
  - The same sequence appears on `out_data` one cycle later with no gaps.
  - `in_ready` stays 1 throughout.
- Stall absorb: `out_ready`=0, send 0xAAAA then 0xBBBB.
  - `occupancy` goes 1 then 2, and `in_ready` drops after the second beat.
  - Raise `out_ready`: 0xAAAA then 0xBBBB appear on consecutive cycles, and `in_ready` returns to 1.
- Flush with both entries full plus an incoming 0xCCCC:
  - Next cycle `out_valid`=0, `out_data`=NOP and `occupancy`=0.
  - 0xCCCC never appears on the output.
- `SKID`=0: `out_ready`=0 with M full gives `in_ready`=0. Raise `out_ready` in the same cycle as `in_valid`: Accept and Fire occur together and M holds the new beat.
- Random `in_valid`/`out_ready` for 10,000 cycles at both `SKID` values: a scoreboard confirms in-order, lossless delivery and `occupancy` ≤ depth.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers.
package pipe_pkg;

  localparam int unsigned PIPE_OCC_W = 2;
  localparam logic [15:0] PIPE_NOP16 = 16'h0000;

  // Concatenated payload widths of each stage boundary.
  localparam int unsigned IF_ID_W  = 64;
  localparam int unsigned ID_EX_W  = 128;
  localparam int unsigned EX_MEM_W = 96;
  localparam int unsigned MEM_WB_W = 72;

  function automatic logic [PIPE_OCC_W-1:0] occCount(input logic mValid, input logic sValid);
    return PIPE_OCC_W'(mValid) + PIPE_OCC_W'(sValid);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus payload; clear wins over load and refills with NOP.
module pipe_slot #(
  parameter int unsigned     WIDTH = 16,
  parameter logic [WIDTH-1:0] NOP  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] dIn,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= NOP;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= NOP;
    end else if (load) begin
      valid <= 1'b1;
      data  <= dIn;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer and flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] NOP   = {WIDTH{1'b0}},
  parameter bit               SKID  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  flush,
  output logic [PIPE_OCC_W-1:0] occupancy
);

  logic             mValid;
  logic             sValid;
  logic [WIDTH-1:0] mData;
  logic             accept;
  logic             fire;

  assign accept    = in_valid & in_ready;
  assign fire      = mValid & out_ready;
  assign out_valid = mValid;
  assign out_data  = mData;
  assign occupancy = occCount(mValid, sValid);

  generate
    if (SKID) begin : gSkid
      logic             mLoad;
      logic             mClear;
      logic             mFromS;
      logic             sLoad;
      logic             sClear;
      logic [WIDTH-1:0] sData;
      logic [WIDTH-1:0] mNext;

      // S only fills while M is stalled, so in_ready never depends on out_ready.
      always_comb begin
        mLoad  = 1'b0;
        mClear = 1'b0;
        mFromS = 1'b0;
        sLoad  = 1'b0;
        sClear = 1'b0;
        if (flush) begin
          mClear = 1'b1;
          sClear = 1'b1;
        end else if (!mValid) begin
          mLoad = accept;
        end else if (fire) begin
          if (sValid) begin
            mLoad  = 1'b1;
            mFromS = 1'b1;
            sClear = 1'b1;
          end else if (accept) begin
            mLoad = 1'b1;
          end else begin
            mClear = 1'b1;
          end
        end else begin
          sLoad = accept;
        end
      end

      assign mNext    = mFromS ? sData : in_data;
      assign in_ready = !sValid;

      pipe_slot #(.WIDTH(WIDTH), .NOP(NOP)) uMain (
        .clk(clk), .reset(reset), .load(mLoad), .clear(mClear),
        .dIn(mNext), .valid(mValid), .data(mData)
      );

      pipe_slot #(.WIDTH(WIDTH), .NOP(NOP)) uSkid (
        .clk(clk), .reset(reset), .load(sLoad), .clear(sClear),
        .dIn(in_data), .valid(sValid), .data(sData)
      );
    end else begin : gSingle
      logic mLoad;
      logic mClear;

      always_comb begin
        mLoad  = 1'b0;
        mClear = 1'b0;
        if (flush) begin
          mClear = 1'b1;
        end else if (accept) begin
          mLoad = 1'b1;
        end else if (fire) begin
          mClear = 1'b1;
        end
      end

      assign sValid   = 1'b0;
      assign in_ready = !mValid | out_ready;

      pipe_slot #(.WIDTH(WIDTH), .NOP(NOP)) uMain (
        .clk(clk), .reset(reset), .load(mLoad), .clear(mClear),
        .dIn(in_data), .valid(mValid), .data(mData)
      );
    end
  endgenerate

endmodule
